// File: rtl/ws281x_pkg.sv
// ws281x_pkg: shared definitions for the WS281x serial receiver.
//   - rx_state_e      : receiver FSM state encoding
//   - NumBitsRgb/Rgbw : the only legal LED word widths
//   - Default*        : timing constants (clk cycles) for a 50 MHz clock
//   - num_bits_legal(): elaboration-time check of the word width
package ws281x_pkg;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_IDLE = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } rx_state_e;

    localparam int unsigned NumBitsRgb  = 24;
    localparam int unsigned NumBitsRgbw = 32;

    // 50 MHz: 0/1 threshold 500 ns, high pulse 100 ns .. 1 us, reset gap 50 us
    localparam int unsigned DefaultThr  = 25;
    localparam int unsigned DefaultHmin = 5;
    localparam int unsigned DefaultHmax = 50;
    localparam int unsigned DefaultRst  = 2500;

    function automatic bit num_bits_legal(input int unsigned n);
        return (n == NumBitsRgb) || (n == NumBitsRgbw);
    endfunction

endpackage

// File: rtl/ws281x_rx_fifo.sv
// ws281x_rx_fifo: count-based synchronous FIFO holding received LED words.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   wr_en, wr_data  : push request and word
//   rd_en           : pop request (ignored while empty)
//   rd_data         : head word, zero while empty
//   empty           : FIFO holds no words
//   drop            : push refused because full with no same-cycle pop
module ws281x_rx_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             drop
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO depth must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full;
    logic             pop;
    logic             push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DepthCnt);
    assign pop     = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = wr_en && (!full || pop);
    assign drop    = wr_en && full && !pop;
    assign rd_data = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: rd_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/ws281x_rx.sv
// ws281x_rx: WS281x single-wire LED data receiver.
// Decodes high-pulse widths on rxd into NUM_BITS words (MSB first), queues them in a
// FIFO and flags frame ends and protocol errors.
// Parameters: NUM_BITS (24 or 32), FIFO_DEPTH (power of 2, >= 2), CNT_W (timer width).
// Ports:
//   clk, reset_n                          : clock, asynchronous active-low reset
//   cfg_enb                               : receiver enable (low forces resync)
//   rxd                                   : asynchronous serial line
//   cfg_thr/cfg_hmin/cfg_hmax/cfg_rst     : timing in clk cycles
//   rx_data, rx_valid, rx_ready           : FIFO head handshake
//   rx_frame_end, err_pulse, err_partial,
//   err_ovf                               : one-cycle event pulses
//   stat_word_cnt, stat_err_cnt           : saturating statistics
// Build option: define WS281X_RX_STAT_EN to implement the statistics counters;
// otherwise they read as zero.
module ws281x_rx
    import ws281x_pkg::*;
#(
    parameter int unsigned NUM_BITS   = 24,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cfg_enb,
    input  logic                rxd,
    input  logic [CNT_W-1:0]    cfg_thr,
    input  logic [CNT_W-1:0]    cfg_hmin,
    input  logic [CNT_W-1:0]    cfg_hmax,
    input  logic [CNT_W-1:0]    cfg_rst,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                rx_frame_end,
    output logic                err_pulse,
    output logic                err_partial,
    output logic                err_ovf,
    output logic [15:0]         stat_word_cnt,
    output logic [15:0]         stat_err_cnt
);

    localparam int unsigned BCW = $clog2(NUM_BITS + 1);
    localparam logic [BCW-1:0] BitsFull = BCW'(NUM_BITS);

    if (!num_bits_legal(NUM_BITS)) begin : g_bad_num_bits
        $error("NUM_BITS must be 24 or 32");
    end

    // Line synchronizer and edge detector
    logic rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic rise, fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta_q <= 1'b0;
            rxd_sync_q <= 1'b0;
            rxd_prev_q <= 1'b0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    assign rise = rxd_sync_q && !rxd_prev_q;
    assign fall = !rxd_sync_q && rxd_prev_q;

    // Decoder FSM
    rx_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d, bit_cnt_inc;
    logic [NUM_BITS-1:0] shift_q, shift_d, shift_next;
    logic [NUM_BITS-1:0] word_q, word_d;
    logic                push_q, push_d;
    logic                frame_end_q, frame_end_d;
    logic                err_pulse_q, err_pulse_d;
    logic                err_partial_q, err_partial_d;
    logic                err_ovf_q;
    logic                new_bit;
    logic                fifo_empty, fifo_drop;

    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign bit_cnt_inc = bit_cnt_q + BCW'(1);
    assign new_bit     = (cnt_q >= cfg_thr);
    assign shift_next  = {shift_q[NUM_BITS-2:0], new_bit};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        word_d        = word_q;
        push_d        = 1'b0;
        frame_end_d   = 1'b0;
        err_pulse_d   = 1'b0;
        err_partial_d = 1'b0;

        if (!cfg_enb) begin
            state_d   = S_SYNC;
            cnt_d     = '0;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else begin
            unique case (state_q)
                // Wait for a full reset gap before trusting any edge.
                S_SYNC: begin
                    if (rxd_sync_q) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= cfg_rst) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end
                    end
                end

                S_IDLE: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d = S_HIGH;
                        cnt_d   = CNT_W'(1);
                    end
                end

                // cnt holds the number of high cycles seen so far.
                S_HIGH: begin
                    if ((cnt_q > cfg_hmax) || (fall && (cnt_q < cfg_hmin))) begin
                        err_pulse_d = 1'b1;
                        state_d     = S_SYNC;
                        cnt_d       = '0;
                        bit_cnt_d   = '0;
                        shift_d     = '0;
                    end else if (fall) begin
                        state_d = S_LOW;
                        cnt_d   = CNT_W'(1);
                        if (bit_cnt_inc == BitsFull) begin
                            push_d    = 1'b1;
                            word_d    = shift_next;
                            bit_cnt_d = '0;
                            shift_d   = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_inc;
                            shift_d   = shift_next;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end

                S_LOW: begin
                    if (rise) begin
                        state_d = S_HIGH;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= cfg_rst) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                            if (bit_cnt_q == '0) begin
                                frame_end_d = 1'b1;
                            end else begin
                                err_partial_d = 1'b1;
                                bit_cnt_d     = '0;
                                shift_d       = '0;
                            end
                        end
                    end
                end

                default: begin
                    state_d = S_SYNC;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_SYNC;
            cnt_q         <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            word_q        <= '0;
            push_q        <= 1'b0;
            frame_end_q   <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_partial_q <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            word_q        <= word_d;
            push_q        <= push_d;
            frame_end_q   <= frame_end_d;
            err_pulse_q   <= err_pulse_d;
            err_partial_q <= err_partial_d;
            err_ovf_q     <= fifo_drop;
        end
    end

    // Completed words enter the FIFO one cycle after their last bit.
    ws281x_rx_fifo #(
        .WIDTH (NUM_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (push_q),
        .wr_data (word_q),
        .rd_en   (rx_ready),
        .rd_data (rx_data),
        .empty   (fifo_empty),
        .drop    (fifo_drop)
    );

    assign rx_valid     = !fifo_empty;
    assign rx_frame_end = frame_end_q;
    assign err_pulse    = err_pulse_q;
    assign err_partial  = err_partial_q;
    assign err_ovf      = err_ovf_q;

`ifdef WS281X_RX_STAT_EN
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [16:0] err_sum;

    // Several error kinds may coincide; each counts as its own event.
    always_comb begin
        word_cnt_d = word_cnt_q;
        if (push_q && !fifo_drop && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
        err_sum = {1'b0, err_cnt_q} + {16'd0, err_pulse_q} + {16'd0, err_partial_q}
                + {16'd0, err_ovf_q};
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign stat_word_cnt = word_cnt_q;
    assign stat_err_cnt  = err_cnt_q;
`else
    assign stat_word_cnt = '0;
    assign stat_err_cnt  = '0;
`endif

endmodule

// File: doc/ws281x_rx.md
WS281X_RX -- requirements
Module: ws281x_rx

Interface
REQ-001 SHALL have parameter NUM_BITS, default 24, bits per LED word (24 RGB or 32 RGBW only).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output word FIFO depth (power of 2, ≥2).
REQ-003 SHALL have parameter CNT_W, default 16, width of the timing counter and timing config fields.
REQ-004 SHALL have ports: clk in 1, single clock; reset_n in 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports: cfg_enb in 1, receiver enable; rxd in 1, asynchronous serial line.
REQ-006 SHALL have ports: cfg_thr, cfg_hmin, cfg_hmax, cfg_rst, each in CNT_W, measured in clk cycles: 0/1 threshold, min high, max high, reset-gap length.
REQ-007 SHALL have ports: rx_data out NUM_BITS; rx_valid out 1; rx_ready in 1, FIFO head handshake.
REQ-008 SHALL have ports: rx_frame_end, err_pulse, err_partial, err_ovf, each out 1, one-cycle pulses.
REQ-009 SHALL have ports: stat_word_cnt out 16; stat_err_cnt out 16.

Function
REQ-010 SHALL pass rxd through a 2-flop synchronizer, then use edge detection on the synchronized value only.
REQ-011 SHALL implement FSM states S_SYNC, S_IDLE, S_HIGH, S_LOW, with one counter cnt (CNT_W, saturating at all-ones).
REQ-012 S_SYNC SHALL count consecutive low cycles, clear on high, and enter S_IDLE when cnt reaches cfg_rst.
REQ-013 S_IDLE SHALL enter S_HIGH on a rising edge with cnt=1.
REQ-014 S_HIGH SHALL pulse err_pulse and enter S_SYNC when cnt exceeds cfg_hmax.
REQ-015 In S_HIGH, a falling edge with cnt<cfg_hmin SHALL pulse err_pulse and enter S_SYNC; otherwise the bit SHALL be (cnt>=cfg_thr), the FSM SHALL enter S_LOW with cnt=1, and bit_cnt SHALL increment.
REQ-016 Bits SHALL be shifted MSB-first, so the first received bit lands in rx_data[NUM_BITS-1].
REQ-017 On the bit making bit_cnt==NUM_BITS, the word SHALL be pushed to the FIFO the next cycle and bit_cnt cleared.
REQ-018 S_LOW SHALL enter S_HIGH (cnt=1) on a rising edge; reaching cnt==cfg_rst SHALL end the frame and enter S_IDLE.
REQ-019 At frame end with bit_cnt==0, the block SHALL pulse rx_frame_end; with bit_cnt!=0, it SHALL pulse err_partial, discard the partial bits, and clear bit_cnt.
REQ-020 Any error SHALL clear bit_cnt and the shift register; words already pushed SHALL be retained.
REQ-021 The FIFO SHALL pop when rx_valid&&rx_ready; rx_valid SHALL equal FIFO non-empty, and rx_data SHALL be the head word.
REQ-022 A push while full without a same-cycle pop SHALL drop the word and pulse err_ovf; a push and pop on a full FIFO in the same cycle SHALL both succeed.
REQ-023 cfg_enb low SHALL force S_SYNC, clear cnt, bit_cnt and the shift register, and leave FIFO contents intact; config changes are legal only while cfg_enb is low.

Reset
REQ-024 On reset_n low: FSM=S_SYNC, synchronizer=0, cnt=0, bit_cnt=0, FIFO empty, rx_valid=0, rx_data=0, all pulses=0, stat counters=0.
REQ-025 Reset asserted mid-word or mid-frame SHALL abort it with no error pulse.

Configuration
REQ-026 With WS281X_RX_STAT_EN defined, stat_word_cnt SHALL count pushed words and stat_err_cnt SHALL count err_pulse/err_partial/err_ovf events; both saturate at 0xFFFF and are cleared only by reset.
REQ-027 Without WS281X_RX_STAT_EN, stat_word_cnt and stat_err_cnt SHALL be tied to 0 and no counter logic is synthesized.

Structure
REQ-028 A shared package ws281x_pkg SHALL hold the FSM state enum, the NUM_BITS legal values, and default timing constants for 50 MHz: THR=25, HMIN=5, HMAX=50, RST=2500.
REQ-029 The FIFO SHALL be a separate sub-module, ws281x_rx_fifo (parametrised width/depth, count-based full/empty).

Verification
All scenarios use clk=50 MHz with cfg_thr=25, cfg_hmin=5, cfg_hmax=50, cfg_rst=2500.
REQ-030 Test: 60 µs low, then 24 bits of 0xA5C3F0 (T0H 350 ns / T1H 700 ns, 1.25 µs period), then 60 µs low. Expected: rx_data=0xA5C3F0 with rx_valid, then one rx_frame_end pulse.
REQ-031 Test: NUM_BITS=32, 0x12345678 sent. Expected: rx_data=0x12345678, stat_word_cnt=1 with the macro defined, stat_word_cnt=0 without it.
REQ-032 Test: high pulse of 60 ns, then a 1.2 µs high pulse. Expected: err_pulse on each, FSM returns to S_SYNC, no word pushed.
REQ-033 Test: 10 bits sent, then a 60 µs low. Expected: err_partial pulse, FIFO stays empty, the next full frame decodes correctly.
REQ-034 Test: rx_ready=0 and 5 words with FIFO_DEPTH=4. Expected: 4 words retained in order, one err_ovf; with rx_ready held 1 on the full FIFO, the simultaneous push/pop yields no err_ovf.
REQ-035 Test: reset_n pulsed low mid-word, and separately cfg_enb dropped mid-word. Expected: no error pulses, bit_cnt=0, and resync required (no word until a full 2500-cycle low gap).
